// File: rtl/instruction_fetch_unit.sv
// IF stage plus IF/ID pipeline register: owns the PC, runs a single-outstanding
// instruction-memory handshake, and applies hazard stalls and ID-stage redirects.
module instruction_fetch_unit #(
  parameter logic [31:0]   RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]   NOP_INSTR = 32'h0000_0013,
  localparam int unsigned  XLEN      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_in,
  input  logic            redirect_valid_in,
  input  logic [XLEN-1:0] redirect_pc_in,
  output logic            imem_req_out,
  output logic [XLEN-1:0] imem_addr_out,
  input  logic            imem_ack_in,
  input  logic [XLEN-1:0] imem_rdata_in,
  output logic            id_valid_out,
  output logic [XLEN-1:0] id_pc_out,
  output logic [XLEN-1:0] id_pc_plus4_out,
  output logic [XLEN-1:0] id_instruction_out
);

  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } ifid_t;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] buf_instr_q, buf_instr_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  ifid_t           ifid_q, ifid_d;

  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] pc_plus4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= FETCH;
      pc_q           <= RESET_PC;
      buf_instr_q    <= NOP_INSTR;
      redir_pc_q     <= '0;
      ifid_q.valid   <= 1'b0;
      ifid_q.pc      <= '0;
      ifid_q.pc_plus4 <= XLEN'(4);
      ifid_q.instr   <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      redir_pc_q  <= redir_pc_d;
      ifid_q      <= ifid_d;
    end
  end

  // Next-state: redirect beats stall beats normal flow in every state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_instr_d = buf_instr_q;
    redir_pc_d  = redir_pc_q;
    ifid_d      = ifid_q;
    redir_tgt   = redirect_pc_in & ALIGN_MASK;
    pc_plus4    = pc_q + XLEN'(4);

    unique case (state_q)
      FETCH: begin
        if (redirect_valid_in) begin
          if (imem_ack_in) begin
            pc_d = redir_tgt;
          end else begin
            // Request stays outstanding at the old address; its data is dropped.
            redir_pc_d = redir_tgt;
            state_d    = DROP;
          end
        end else if (imem_ack_in) begin
          if (stall_in) begin
            buf_instr_d = imem_rdata_in;
            state_d     = HOLD;
          end else begin
            ifid_d.valid    = 1'b1;
            ifid_d.pc       = pc_q;
            ifid_d.pc_plus4 = pc_plus4;
            ifid_d.instr    = imem_rdata_in;
            pc_d            = pc_plus4;
          end
        end else if (!stall_in) begin
          ifid_d.valid = 1'b0;
          ifid_d.instr = NOP_INSTR;
        end
      end
      HOLD: begin
        if (redirect_valid_in) begin
          pc_d    = redir_tgt;
          state_d = FETCH;
        end else if (!stall_in) begin
          ifid_d.valid    = 1'b1;
          ifid_d.pc       = pc_q;
          ifid_d.pc_plus4 = pc_plus4;
          ifid_d.instr    = buf_instr_q;
          pc_d            = pc_plus4;
          state_d         = FETCH;
        end
      end
      DROP: begin
        if (redirect_valid_in) begin
          redir_pc_d = redir_tgt;
        end
        if (imem_ack_in) begin
          pc_d    = redirect_valid_in ? redir_tgt : redir_pc_q;
          state_d = FETCH;
        end
        if (!stall_in) begin
          ifid_d.valid = 1'b0;
          ifid_d.instr = NOP_INSTR;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (redirect_valid_in) begin
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP_INSTR;
    end
  end

  assign imem_req_out       = (state_q != HOLD);
  assign imem_addr_out      = pc_q;
  assign id_valid_out       = ifid_q.valid;
  assign id_pc_out          = ifid_q.pc;
  assign id_pc_plus4_out    = ifid_q.pc_plus4;
  assign id_instruction_out = ifid_q.instr;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a randomized run
// against a transaction-level model of the fetch stream.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] SALT  = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in;
  logic [31:0] imem_rdata_in;
  logic        id_valid_out;
  logic [31:0] id_pc_out;
  logic [31:0] id_pc_plus4_out;
  logic [31:0] id_instruction_out;

  int total = 0;
  int bad   = 0;

  // memory responder state
  int mem_cnt  = 0;
  int mem_lat  = 0;
  bit mem_rand = 1'b0;

  // reference model: fetched-but-unissued instruction, fetch address, wrong-path flag
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t        m_buf[$];
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_fetch;
  logic [31:0] m_target;
  bit          m_wrong;

  instruction_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .stall_in           (stall_in),
    .redirect_valid_in  (redirect_valid_in),
    .redirect_pc_in     (redirect_pc_in),
    .imem_req_out       (imem_req_out),
    .imem_addr_out      (imem_addr_out),
    .imem_ack_in        (imem_ack_in),
    .imem_rdata_in      (imem_rdata_in),
    .id_valid_out       (id_valid_out),
    .id_pc_out          (id_pc_out),
    .id_pc_plus4_out    (id_pc_plus4_out),
    .id_instruction_out (id_instruction_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_step(input logic rst_v, input logic st, input logic rd,
                            input logic [31:0] tgt, input logic ack_v, input logic [31:0] rdat);
    logic [31:0] t;
    t = tgt & 32'hFFFF_FFFC;
    if (rst_v) begin
      m_valid = 1'b0; m_pc = 32'h0; m_instr = NOP;
      m_fetch = 32'h0; m_target = 32'h0; m_wrong = 1'b0;
      m_buf.delete();
    end else if (rd) begin
      m_valid = 1'b0; m_instr = NOP;
      if (m_buf.size() == 0 && !ack_v) begin
        m_wrong  = 1'b1;
        m_target = t;
      end else begin
        m_fetch = t;
        m_wrong = 1'b0;
      end
      m_buf.delete();
    end else if (m_buf.size() != 0) begin
      if (!st) begin
        m_valid = 1'b1; m_pc = m_buf[0].pc; m_instr = m_buf[0].instr;
        m_buf.delete();
      end
    end else if (ack_v && m_wrong) begin
      m_fetch = m_target;
      m_wrong = 1'b0;
      if (!st) begin m_valid = 1'b0; m_instr = NOP; end
    end else if (ack_v) begin
      if (st) m_buf.push_back('{pc: m_fetch, instr: rdat});
      else begin m_valid = 1'b1; m_pc = m_fetch; m_instr = rdat; end
      m_fetch = m_fetch + 32'd4;
    end else if (!st) begin
      m_valid = 1'b0; m_instr = NOP;
    end
  endtask

  // Drive one cycle of inputs, answer the memory, advance the model, land #1 after the edge.
  task automatic tick(input logic rst_v, input logic st, input logic rd, input logic [31:0] tgt);
    logic        ack_v;
    logic [31:0] rdat;
    ack_v = imem_req_out && (mem_cnt >= mem_lat);
    rdat  = ack_v ? (imem_addr_out ^ SALT) : $urandom();
    reset             = rst_v;
    stall_in          = st;
    redirect_valid_in = rd;
    redirect_pc_in    = tgt;
    imem_ack_in       = ack_v;
    imem_rdata_in     = rdat;
    model_step(rst_v, st, rd, tgt, ack_v, rdat);
    if (rst_v || ack_v) begin
      mem_cnt = 0;
      if (mem_rand) mem_lat = $urandom_range(0, 2);
    end else if (imem_req_out) begin
      mem_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    mem_rand = 1'b0; mem_lat = 0;
    do_reset();
    total++; if (id_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", id_valid_out); end
    total++; if (id_pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", id_pc_out); end
    total++; if (id_pc_plus4_out !== 32'h4) begin bad++; $display("FAIL reset_pc4: got %h want 4", id_pc_plus4_out); end
    total++; if (id_instruction_out !== NOP) begin bad++; $display("FAIL reset_instr: got %h want %h", id_instruction_out, NOP); end
    total++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0) begin bad++; $display("FAIL reset_req: got req=%b addr=%h want req=1 addr=0", imem_req_out, imem_addr_out); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc;
    mem_rand = 1'b0; mem_lat = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      exp_pc = 32'(k) * 32'd4;
      total++; if (id_valid_out !== 1'b1) begin bad++; $display("FAIL zw_valid[%0d]: got %b want 1", k, id_valid_out); end
      total++; if (id_pc_out !== exp_pc) begin bad++; $display("FAIL zw_pc[%0d]: got %h want %h", k, id_pc_out, exp_pc); end
      total++; if (id_pc_plus4_out !== exp_pc + 32'd4) begin bad++; $display("FAIL zw_pc4[%0d]: got %h want %h", k, id_pc_plus4_out, exp_pc + 32'd4); end
      total++; if (id_instruction_out !== (exp_pc ^ SALT)) begin bad++; $display("FAIL zw_instr[%0d]: got %h want %h", k, id_instruction_out, exp_pc ^ SALT); end
    end
  endtask

  task automatic test_stall_during_ack();
    mem_rand = 1'b0; mem_lat = 0;
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      total++; if (id_pc_out !== 32'h4 || id_valid_out !== 1'b1) begin bad++; $display("FAIL stall_hold[%0d]: got pc=%h v=%b want pc=4 v=1", k, id_pc_out, id_valid_out); end
      total++; if (imem_req_out !== 1'b0) begin bad++; $display("FAIL stall_req[%0d]: got %b want 0", k, imem_req_out); end
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (id_pc_out !== 32'h8 || id_valid_out !== 1'b1) begin bad++; $display("FAIL stall_release_pc: got pc=%h v=%b want pc=8 v=1", id_pc_out, id_valid_out); end
    total++; if (id_instruction_out !== (32'h8 ^ SALT)) begin bad++; $display("FAIL stall_release_instr: got %h want %h", id_instruction_out, 32'h8 ^ SALT); end
    total++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'hC) begin bad++; $display("FAIL stall_next_req: got req=%b addr=%h want req=1 addr=c", imem_req_out, imem_addr_out); end
  endtask

  task automatic test_redirect_stall();
    mem_rand = 1'b0; mem_lat = 0;
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 32'h0000_0102);
    total++; if (id_valid_out !== 1'b0 || id_instruction_out !== NOP) begin bad++; $display("FAIL rs_flush: got v=%b instr=%h want v=0 instr=%h", id_valid_out, id_instruction_out, NOP); end
    total++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h100) begin bad++; $display("FAIL rs_addr: got req=%b addr=%h want req=1 addr=100", imem_req_out, imem_addr_out); end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (id_valid_out !== 1'b1 || id_pc_out !== 32'h100 || id_pc_plus4_out !== 32'h104) begin bad++; $display("FAIL rs_target: got v=%b pc=%h pc4=%h want v=1 pc=100 pc4=104", id_valid_out, id_pc_out, id_pc_plus4_out); end
  endtask

  task automatic test_redirect_mid_request();
    bit seen40;
    bit done;
    mem_rand = 1'b0; mem_lat = 0;
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    mem_lat = 3;
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 32'h0000_0040);
    total++; if (imem_addr_out !== 32'h8 || imem_req_out !== 1'b1) begin bad++; $display("FAIL mid_hold_addr: got req=%b addr=%h want req=1 addr=8", imem_req_out, imem_addr_out); end
    total++; if (id_valid_out !== 1'b0) begin bad++; $display("FAIL mid_flush: got %b want 0", id_valid_out); end
    seen40 = 1'b0;
    done   = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      if (id_valid_out === 1'b1) begin
        done = 1'b1;
        total++; if (id_pc_out !== 32'h40 || !seen40) begin bad++; $display("FAIL mid_first_valid: got pc=%h seen40=%b want pc=40 seen40=1", id_pc_out, seen40); end
      end else begin
        if (imem_addr_out === 32'h40) seen40 = 1'b1;
        total++;
        if ((seen40 && imem_addr_out !== 32'h40) || (!seen40 && imem_addr_out !== 32'h8)) begin
          bad++; $display("FAIL mid_addr[%0d]: got %h want %h", k, imem_addr_out, seen40 ? 32'h40 : 32'h8);
        end
      end
    end
    total++; if (!done) begin bad++; $display("FAIL mid_timeout: got no valid instruction want pc=40 within 12 cycles"); end
    mem_lat = 0;
  endtask

  task automatic test_wrap();
    mem_rand = 1'b0; mem_lat = 0;
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    total++; if (imem_addr_out !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr0: got %h want fffffffc", imem_addr_out); end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (id_pc_out !== 32'hFFFF_FFFC || id_pc_plus4_out !== 32'h0) begin bad++; $display("FAIL wrap_pc4: got pc=%h pc4=%h want pc=fffffffc pc4=0", id_pc_out, id_pc_plus4_out); end
    total++; if (imem_addr_out !== 32'h0) begin bad++; $display("FAIL wrap_addr1: got %h want 0", imem_addr_out); end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (id_pc_out !== 32'h0 || id_instruction_out !== SALT) begin bad++; $display("FAIL wrap_next: got pc=%h instr=%h want pc=0 instr=%h", id_pc_out, id_instruction_out, SALT); end
  endtask

  task automatic test_reset_mid_hold();
    mem_rand = 1'b0; mem_lat = 0;
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    total++; if (imem_req_out !== 1'b0) begin bad++; $display("FAIL rmh_hold: got req=%b want 0", imem_req_out); end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (id_valid_out !== 1'b0 || id_instruction_out !== NOP) begin bad++; $display("FAIL rmh_ifid: got v=%b instr=%h want v=0 instr=%h", id_valid_out, id_instruction_out, NOP); end
    total++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0) begin bad++; $display("FAIL rmh_req: got req=%b addr=%h want req=1 addr=0", imem_req_out, imem_addr_out); end
  endtask

  task automatic test_random();
    logic        st, rd, rst_v, exp_req;
    logic [31:0] tgt;
    mem_rand = 1'b1; mem_lat = $urandom_range(0, 2);
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst_v = ($urandom_range(0, 199) == 0);
      st    = ($urandom_range(0, 3) == 0);
      rd    = ($urandom_range(0, 9) == 0);
      tgt   = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'h0000_1000) | ($urandom & 32'hFF);
      tick(rst_v, st, rd, tgt);
      exp_req = (m_buf.size() == 0);
      total++; if (imem_req_out !== exp_req) begin bad++; $display("FAIL rnd_req[%0d]: got %b want %b", k, imem_req_out, exp_req); end
      if (exp_req) begin
        total++; if (imem_addr_out !== m_fetch) begin bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", k, imem_addr_out, m_fetch); end
      end
      total++; if (id_valid_out !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", k, id_valid_out, m_valid); end
      total++; if (id_pc_out !== m_pc) begin bad++; $display("FAIL rnd_pc[%0d]: got %h want %h", k, id_pc_out, m_pc); end
      total++; if (id_pc_plus4_out !== m_pc + 32'd4) begin bad++; $display("FAIL rnd_pc4[%0d]: got %h want %h", k, id_pc_plus4_out, m_pc + 32'd4); end
      total++; if (id_instruction_out !== m_instr) begin bad++; $display("FAIL rnd_instr[%0d]: got %h want %h", k, id_instruction_out, m_instr); end
    end
    mem_rand = 1'b0; mem_lat = 0;
  endtask

  initial begin
    reset             = 1'b1;
    stall_in          = 1'b0;
    redirect_valid_in = 1'b0;
    redirect_pc_in    = 32'h0;
    imem_ack_in       = 1'b0;
    imem_rdata_in     = 32'h0;
    m_valid = 1'b0; m_pc = 32'h0; m_instr = NOP;
    m_fetch = 32'h0; m_target = 32'h0; m_wrong = 1'b0;
    test_reset();
    test_zero_wait();
    test_stall_during_ack();
    test_redirect_stall();
    test_redirect_mid_request();
    test_wrap();
    test_reset_mid_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
